// File: rtl/adder_seq_ctrl_r4.sv
// Sequencer that steps the radix-4 online adder through eight stored vectors,
// streams operand digits MSD-first, collects the delayed result and scores it.
module adder_seq_ctrl_r4 #(
    parameter int unsigned n   = 6,
    parameter int unsigned c   = 3,
    parameter int unsigned LAT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [2:0]           test_select,
    input  logic [n*c-1:0]       x_vec,
    input  logic [n*c-1:0]       y_vec,
    input  logic [(n+1)*c-1:0]   z_vec,
    output logic                 adder_clr,
    output logic                 adder_en,
    output logic [c-1:0]         x_digit,
    output logic [c-1:0]         y_digit,
    input  logic [c-1:0]         sum_digit,
    output logic                 busy,
    output logic                 done,
    output logic [3:0]           pass_count,
    output logic [7:0]           fail_mask
);

    localparam int unsigned OPW       = n * c;
    localparam int unsigned RESW      = (n + 1) * c;
    localparam int unsigned FEED_LAST = n + LAT;
    localparam int unsigned KW        = $clog2(FEED_LAST + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLR,
        S_FEED,
        S_CHECK,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [2:0]      sel_q, sel_d;
    logic [OPW-1:0]  x_r_q, x_r_d;
    logic [OPW-1:0]  y_r_q, y_r_d;
    logic [RESW-1:0] z_r_q, z_r_d;
    logic [RESW-1:0] res_q, res_d;
    logic [3:0]      pass_q, pass_d;
    logic [7:0]      fail_q, fail_d;
    logic            clr_q, clr_d;
    logic            en_q, en_d;
    logic [c-1:0]    xd_q, xd_d;
    logic [c-1:0]    yd_q, yd_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // Digit k of an operand (MSD at k=0); zero once k runs past the last digit.
    function automatic logic [c-1:0] op_digit(input logic [OPW-1:0] v, input logic [KW-1:0] k);
        op_digit = '0;
        for (int unsigned i = 0; i < n; i++) begin
            if (k == KW'(i)) op_digit = v[(n-i)*c-1 -: c];
        end
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            sel_q   <= '0;
            x_r_q   <= '0;
            y_r_q   <= '0;
            z_r_q   <= '0;
            res_q   <= '0;
            pass_q  <= '0;
            fail_q  <= '0;
            clr_q   <= 1'b0;
            en_q    <= 1'b0;
            xd_q    <= '0;
            yd_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            sel_q   <= sel_d;
            x_r_q   <= x_r_d;
            y_r_q   <= y_r_d;
            z_r_q   <= z_r_d;
            res_q   <= res_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            clr_q   <= clr_d;
            en_q    <= en_d;
            xd_q    <= xd_d;
            yd_q    <= yd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        sel_d   = sel_q;
        x_r_d   = x_r_q;
        y_r_d   = y_r_q;
        z_r_d   = z_r_q;
        res_d   = res_q;
        pass_d  = pass_q;
        fail_d  = fail_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    sel_d   = '0;
                    pass_d  = '0;
                    fail_d  = '0;
                end
            end
            S_LOAD: begin
                x_r_d   = x_vec;
                y_r_d   = y_vec;
                z_r_d   = z_vec;
                state_d = S_CLR;
            end
            S_CLR: begin
                k_d     = '0;
                res_d   = '0;
                state_d = S_FEED;
            end
            S_FEED: begin
                // Result digit j arrives LAT feed cycles after operand digit j.
                for (int unsigned j = 0; j <= n; j++) begin
                    if (k_q == KW'(j + LAT)) res_d[(n+1-j)*c-1 -: c] = sum_digit;
                end
                if (k_q == KW'(FEED_LAST)) begin
                    k_d     = '0;
                    state_d = S_CHECK;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_CHECK: begin
                if (res_q == z_r_q) pass_d = pass_q + 4'd1;
                else                fail_d[sel_q] = 1'b1;
                if (sel_q == 3'd7) begin
                    state_d = S_DONE;
                end else begin
                    sel_d   = sel_q + 3'd1;
                    state_d = S_LOAD;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are computed from the next state so they register in step with it.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        clr_d  = (state_d == S_CLR);
        en_d   = (state_d == S_FEED);
        xd_d   = en_d ? op_digit(x_r_q, k_d) : '0;
        yd_d   = en_d ? op_digit(y_r_q, k_d) : '0;
    end

    assign test_select = sel_q;
    assign adder_clr   = clr_q;
    assign adder_en    = en_q;
    assign x_digit     = xd_q;
    assign y_digit     = yd_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass_count  = pass_q;
    assign fail_mask   = fail_q;

endmodule

// File: tb/tb_adder_seq_ctrl_r4.sv
// Bench for adder_seq_ctrl_r4: vector table, behavioural online adder with
// fault modes, and directed runs scored against hand-computed results.
module tb_adder_seq_ctrl_r4;

    localparam int unsigned N   = 6;
    localparam int unsigned C   = 3;
    localparam int unsigned LAT = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [2:0]           test_select;
    logic [N*C-1:0]       x_vec;
    logic [N*C-1:0]       y_vec;
    logic [(N+1)*C-1:0]   z_vec;
    logic                 adder_clr;
    logic                 adder_en;
    logic [C-1:0]         x_digit;
    logic [C-1:0]         y_digit;
    logic [C-1:0]         sum_digit;
    logic                 busy;
    logic                 done;
    logic [3:0]           pass_count;
    logic [7:0]           fail_mask;

    always #5 clk = ~clk;

    adder_seq_ctrl_r4 #(.n(N), .c(C), .LAT(LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .test_select (test_select),
        .x_vec       (x_vec),
        .y_vec       (y_vec),
        .z_vec       (z_vec),
        .adder_clr   (adder_clr),
        .adder_en    (adder_en),
        .x_digit     (x_digit),
        .y_digit     (y_digit),
        .sum_digit   (sum_digit),
        .busy        (busy),
        .done        (done),
        .pass_count  (pass_count),
        .fail_mask   (fail_mask)
    );

    // Digits MSD first; z is x+y recoded with transfer t in {-1,0,1}, remainder w in {-2..2}.
    int xd [8][N] = '{
        '{ 1, -2,  3,  0, -1,  2},
        '{ 3,  1,  0,  0,  0,  0},
        '{ 0,  0,  0,  1,  2, -2},
        '{ 0,  2, -3,  1,  0,  3},
        '{-3, -3, -3, -3, -3, -3},
        '{ 1,  1,  1,  1,  1,  1},
        '{-2,  0,  1,  0,  0,  0},
        '{ 2, -1,  2, -1,  2, -1}};
    int yd [8][N] = '{
        '{-1,  2, -3,  0,  1, -2},
        '{ 3,  0,  0,  0,  0,  0},
        '{ 0,  0,  0,  1, -1,  3},
        '{ 0,  1, -1,  2,  0,  3},
        '{-3, -3, -3, -3, -3, -3},
        '{ 0,  0,  0,  0,  0,  1},
        '{-1,  3,  0,  0,  2, -1},
        '{ 2,  2,  2,  2,  2,  2}};
    int zd [8][N+1] = '{
        '{ 0,  0,  0,  0,  0,  0,  0},
        '{ 1,  2,  1,  0,  0,  0,  0},
        '{ 0,  0,  0,  1, -2,  1,  1},
        '{ 0,  1, -2,  1, -1,  1,  2},
        '{-1, -3, -3, -3, -3, -3, -2},
        '{ 0,  1,  1,  1,  1,  2, -2},
        '{-1,  2, -1,  1,  1, -2, -1},
        '{ 1,  0,  2,  0,  2,  0,  1}};

    always_comb begin
        x_vec = '0;
        y_vec = '0;
        z_vec = '0;
        for (int k = 0; k < N; k++) begin
            x_vec[(N-k)*C-1 -: C] = C'(xd[test_select][k]);
            y_vec[(N-k)*C-1 -: C] = C'(yd[test_select][k]);
        end
        for (int k = 0; k <= N; k++) begin
            z_vec[(N+1-k)*C-1 -: C] = C'(zd[test_select][k]);
        end
    end

    // Adder model. mode 0: correct, LAT=2; 1: result MSD forced to 0; 2: LAT=1.
    int           mode;
    int           p_m, t_m, w_m, z_m;
    int           w_prev_m, k_m;
    logic [C-1:0] sh0_m, sh1_m;

    always_comb begin
        p_m = int'($signed(x_digit)) + int'($signed(y_digit));
        if (p_m >= 2) begin
            t_m = 1;
            w_m = p_m - 4;
        end else if (p_m <= -2) begin
            t_m = -1;
            w_m = p_m + 4;
        end else begin
            t_m = 0;
            w_m = p_m;
        end
        z_m = w_prev_m + t_m;
        if (mode == 1 && k_m == 0) z_m = 0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_prev_m <= 0;
            k_m      <= 0;
            sh0_m    <= '0;
            sh1_m    <= '0;
        end else if (adder_clr) begin
            w_prev_m <= 0;
            k_m      <= 0;
            sh0_m    <= '0;
            sh1_m    <= '0;
        end else if (adder_en) begin
            sh0_m    <= C'(z_m);
            sh1_m    <= sh0_m;
            w_prev_m <= w_m;
            k_m      <= k_m + 1;
        end
    end

    assign sum_digit = (mode == 2) ? sh0_m : sh1_m;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, " test_select"}, 32'(test_select), 32'd0);
        check_eq({tag, " adder_clr"},   32'(adder_clr),   32'd0);
        check_eq({tag, " adder_en"},    32'(adder_en),    32'd0);
        check_eq({tag, " x_digit"},     32'(x_digit),     32'd0);
        check_eq({tag, " y_digit"},     32'(y_digit),     32'd0);
        check_eq({tag, " busy"},        32'(busy),        32'd0);
        check_eq({tag, " done"},        32'(done),        32'd0);
        check_eq({tag, " pass_count"},  32'(pass_count),  32'd0);
        check_eq({tag, " fail_mask"},   32'(fail_mask),   32'd0);
    endtask

    // Full run from a start pulse; cycle 1 is the first cycle after the accepting edge.
    task automatic do_run(input int repulse_cyc, input int exp_pass, input int exp_mask, input string tag);
        int           done_cyc, done_cnt, busy_cnt, clr_cnt2, clr_cyc2, en_cyc2, idle_nz;
        logic [C-1:0] xs[$];
        logic [C-1:0] ys[$];
        logic [26:0]  xpk, ypk;
        done_cyc = -1; done_cnt = 0; busy_cnt = 0;
        clr_cnt2 = 0; clr_cyc2 = -1; en_cyc2 = -1; idle_nz = 0;
        xpk = '0; ypk = '0;
        start = 1'b1;
        cyc   = 0;
        step();
        start = 1'b0;
        while (cyc <= 100) begin
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (busy) busy_cnt++;
            if (!adder_en && (x_digit != '0 || y_digit != '0)) idle_nz++;
            if (test_select == 3'd2 && adder_clr) begin
                clr_cnt2++;
                clr_cyc2 = cyc;
            end
            if (test_select == 3'd2 && adder_en) begin
                if (en_cyc2 < 0) en_cyc2 = cyc;
                xs.push_back(x_digit);
                ys.push_back(y_digit);
            end
            start = (cyc == repulse_cyc);
            step();
        end
        start = 1'b0;
        for (int i = 0; i < xs.size() && i < 9; i++) begin
            xpk = {xpk[23:0], xs[i]};
            ypk = {ypk[23:0], ys[i]};
        end
        check_eq({tag, " done_cycle"},  done_cyc, 32'd97);
        check_eq({tag, " done_pulses"}, done_cnt, 32'd1);
        check_eq({tag, " busy_cycles"}, busy_cnt, 32'd97);
        check_eq({tag, " busy_after"},  32'(busy), 32'd0);
        check_eq({tag, " pass_count"},  32'(pass_count), exp_pass);
        check_eq({tag, " fail_mask"},   32'(fail_mask),  exp_mask);
        check_eq({tag, " idle_digits"}, idle_nz, 32'd0);
        check_eq({tag, " v2_clr_count"}, clr_cnt2, 32'd1);
        check_eq({tag, " v2_clr_cycle"}, clr_cyc2, 32'd26);
        check_eq({tag, " v2_en_cycle"},  en_cyc2,  32'd27);
        check_eq({tag, " v2_feed_len"},  xs.size(), 32'd9);
        check_eq({tag, " v2_x_seq"},     32'(xpk), 32'o000126000);
        check_eq({tag, " v2_y_seq"},     32'(ypk), 32'o000173000);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        mode  = 0;
        #12;
        check_all_zero("reset");
        #10;
        reset = 1'b0;

        mode = 0;
        do_run(0, 8, 'h00, "golden");
        for (int i = 0; i < 3; i++) step();
        check_eq("hold pass_count", 32'(pass_count), 32'd8);
        check_eq("hold busy",       32'(busy),       32'd0);

        mode = 1;
        do_run(0, 4, 'hD2, "msd_fault");

        mode = 2;
        do_run(0, 1, 'hFE, "lat1");

        mode = 0;
        do_run(40, 8, 'h00, "restart40");

        // start held high: a second run is accepted straight out of DONE.
        start = 1'b1;
        cyc   = 0;
        step();
        while (cyc < 97) step();
        check_eq("held done@97",        32'(done),       32'd1);
        step();
        check_eq("held busy@98",        32'(busy),       32'd0);
        check_eq("held pass@98",        32'(pass_count), 32'd8);
        step();
        check_eq("held busy@99",        32'(busy),        32'd1);
        check_eq("held pass@99",        32'(pass_count),  32'd0);
        check_eq("held sel@99",         32'(test_select), 32'd0);
        start = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;

        // Reset mid-FEED of vector 2.
        mode  = 0;
        start = 1'b1;
        cyc   = 0;
        step();
        start = 1'b0;
        while (cyc < 30) step();
        check_eq("mid sel@30", 32'(test_select), 32'd2);
        check_eq("mid en@30",  32'(adder_en),    32'd1);
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        step();
        check_eq("reset held busy", 32'(busy), 32'd0);
        reset = 1'b0;
        do_run(0, 8, 'h00, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
